// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream mux with direct or round-robin select and a registered output stage
module stream_mux_rr #(
  parameter int N = 4,
  parameter int W = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  input  logic            rr_en,
  input  logic [SELW-1:0] sel,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_chan,
  input  logic            out_ready
);
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_chan_q, out_chan_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] gnt;
  logic            gnt_ok;
  logic [W-1:0]    gnt_data;
  logic            can_accept;
  logic            xfer;
  int              best;

  assign can_accept = !out_valid_q || out_ready;
  assign xfer       = |(in_valid & in_ready);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_chan   = out_chan_q;

  // grant: direct index, or the valid channel nearest after ptr in circular order
  always_comb begin
    gnt    = '0;
    gnt_ok = 1'b0;
    best   = N;
    if (!rr_en) begin
      gnt    = sel;
      gnt_ok = int'(sel) < N;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && ((i - int'(ptr_q) + 2*N - 1) % N) < best) begin
          best   = (i - int'(ptr_q) + 2*N - 1) % N;
          gnt    = SELW'(i);
          gnt_ok = 1'b1;
        end
      end
    end
  end

  // ready goes only to the granted channel, and only when the output slot can take a beat
  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (SELW'(i) == gnt) gnt_data = in_data[i*W +: W];
      in_ready[i] = rst_n && can_accept && gnt_ok && (SELW'(i) == gnt);
    end
  end

  // next state of the output slot and the round-robin pointer
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_chan_d  = gnt;
      ptr_d       = gnt;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // state registers; reset leaves ptr on N-1 so channel 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= SELW'(N-1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end
endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes on every input and on the output. It supports a direct-select mode and a round-robin arbitration mode, and registers the selected beat in a single-entry output stage. It sits between several independent producers and one consumer, and replaces plain combinational data muxes wherever back-pressure or fair sharing is needed.

## Interface
- N, default 4: number of input channels, 2..16, need not be a power of two.
- W, default 4: data width per channel, at least 1.
- SELW, default $clog2(N): width of the channel index; derived, not overridden.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous assert and active-low; deassertion is synchronous to clk.
- in_valid  in  N: per-channel valid; bit i belongs to channel i.
- in_data  in  N*W: packed data; channel i occupies [i*W +: W].
- in_ready  out  N: per-channel ready; combinational.
- rr_en  in  1: 1 selects round-robin arbitration, 0 selects direct mode.
- sel  in  SELW: channel index used in direct mode.
- out_valid  out  1: the output register holds a beat.
- out_data  out  W: registered data of the held beat.
- out_chan  out  SELW: registered index of the channel that supplied the beat.
- out_ready  in  1: consumer accepts the beat.

## Operation
- Terminology:
  - An input transfer on channel i occurs when in_valid[i] and in_ready[i] are both 1 at a rising edge.
  - An output transfer occurs when out_valid and out_ready are both 1 at a rising edge.
- can_accept = !out_valid || out_ready. The output register accepts a new beat in the same cycle it drains the old one, so throughput is one beat per cycle.
- Grant, combinational:
  - Direct mode (rr_en=0): grant = sel. If sel >= N, there is no grant.
  - Round-robin mode (rr_en=1): scan channels ptr+1, ptr+2, ... modulo N. Grant the first channel with in_valid set. If no channel is valid, there is no grant.
- in_ready[i] = can_accept && grant exists && i == grant. At most one in_ready bit is 1 at any time.
- In direct mode, in_ready[sel] is independent of in_valid[sel].
- In round-robin mode, in_ready goes only to a valid channel.
- On an input transfer from channel g:
  - out_data <= that channel's data.
  - out_chan <= g.
  - out_valid <= 1.
  - ptr <= g. This update happens in either mode.
- On an output transfer with no simultaneous input transfer, out_valid <= 0. out_data and out_chan keep their last values.
- While out_valid && !out_ready, out_data and out_chan stay stable and all in_ready bits are 0.
- ptr wraps from N-1 to 0. After reset ptr = N-1, so channel 0 has first priority.
- rr_en and sel may change on any cycle. The new value applies to the grant in that same cycle. The beat already held is not affected.
- Reset mid-operation: any held beat is discarded and every output returns to its reset value immediately.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=N-1. in_ready is all zeros while rst_n=0.
- Latency: an input transfer at edge k makes out_valid=1 with the matching data and channel after edge k. A consumer asserting out_ready may complete the output transfer at edge k+1.
- in_ready has a combinational path from in_valid, rr_en, sel, out_valid and out_ready.
- out_data, out_chan and out_valid are driven directly from flops.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, grants rotate 0,1,...,N-1,0. Each channel receives exactly one beat in every N consecutive cycles.

## Test plan
- Direct mode passthrough, N=4, W=4:
  - Stimulus: rr_en=0, in_data = {d3=D, d2=C, d1=B, d0=A}, all valid, out_ready=1, sel stepped 0,1,2,3.
  - Required: out_data A, B, C, D with out_chan 0..3, each one cycle after its sel.
- Back-pressure:
  - Stimulus: rr_en=0, sel=1, in_data channel 1 = 5, out_ready=0 for 3 cycles.
  - Required: out_valid=1 with out_data=5 held for all 3 cycles and in_ready=0.
  - Then raise out_ready with channel 1 now 6. Required: out_data=6 on the next cycle, with no bubble.
- Round-robin rotation:
  - Stimulus: rr_en=1, all valid, channel i data = i+8, out_ready=1.
  - Required: out_chan sequence 0,1,2,3,0 and out_data 8,9,10,11,8.
- Sparse round robin:
  - Stimulus: rr_en=1, only channels 1 and 3 valid.
  - Required: alternating grants 1,3,1,3. Channels 0 and 2 never see in_ready=1.
- Out-of-range select and idle:
  - Stimulus: N=3, rr_en=0, sel=3.
  - Required: in_ready=000 and out_valid stays 0.
  - Stimulus: rr_en=1 with all in_valid=0.
  - Required: no transfers and out_valid stays 0.
- Async reset:
  - Stimulus: assert rst_n=0 between edges while out_valid=1.
  - Required: out_valid, out_data and out_chan go to 0 without waiting for an edge.
  - After release with all channels valid, the first grant is channel 0.
